// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says round controller.
package simon_pkg;

  localparam int ROUND_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_GAP,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_IN,
    ST_RELEASE,
    ST_LOSE,
    ST_WIN
  } state_t;

  function automatic logic [3:0] code2led(logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/fsm_sig.sv
// Handshake between the round controller and the external verify_input block.
interface fsm_sig;
  import simon_pkg::*;

  logic [ROUND_W-1:0] check_round;
  logic               result;

  modport ctrl   (output check_round, input result);
  modport verify (input check_round, output result);
endinterface

// File: rtl/simon_round_ctrl_tick_timer.sv
// Saturating dwell counter; done is high on the last cycle of a target-length phase.
module tick_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] target,
  output logic         done
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (count && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // cnt_reg is 0 on the first cycle of a phase, so the phase ends at target-1.
  assign done = (cnt_reg >= (target - 1'b1));

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon Says sequencer: plays the pattern on the LEDs, then checks presses via verify_input.
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_ROUND     = 33,
  parameter int SHOW_TICKS    = 25,
  parameter int GAP_TICKS     = 10,
  parameter int TIMEOUT_TICKS = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [32:0][1:0]    segment,
  input  logic [3:0]          player_input,
  fsm_sig.ctrl                sigs,
  output logic [3:0]          led_out,
  output logic [ROUND_W-1:0]  round,
  output logic                busy_show,
  output logic                game_over,
  output logic                game_won
);

  localparam int MAX_TICK_A = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int MAX_TICK   = (TIMEOUT_TICKS > MAX_TICK_A) ? TIMEOUT_TICKS : MAX_TICK_A;
  localparam int TW         = $clog2(MAX_TICK) + 1;

  localparam logic [TW-1:0] SHOW_T = TW'(SHOW_TICKS);
  localparam logic [TW-1:0] GAP_T  = TW'(GAP_TICKS);
  localparam logic [TW-1:0] TO_T   = (TIMEOUT_TICKS > 0) ? TW'(TIMEOUT_TICKS) : TW'(1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUND - 1);

  state_t             state_reg;
  logic [ROUND_W-1:0] round_reg;
  logic [ROUND_W-1:0] idx_reg;
  logic [ROUND_W-1:0] check_round_reg;
  logic [3:0]         led_reg;
  logic [3:0]         prev_input_reg;
  logic               busy_reg;
  logic               over_reg;
  logic               won_reg;

  logic               press_edge;
  logic               timeout_hit;
  logic               tmr_load;
  logic               tmr_count;
  logic               tmr_done;
  logic [TW-1:0]      tmr_target;

  assign press_edge  = (prev_input_reg == 4'h0) && (player_input != 4'h0);
  assign timeout_hit = (TIMEOUT_TICKS > 0) && tmr_done;
  assign tmr_count   = (state_reg != ST_IDLE) && (state_reg != ST_LOSE);

  // One timer serves every phase, so it restarts on each state change (and each WIN blink).
  always_comb begin
    tmr_load   = 1'b0;
    tmr_target = TW'(1);
    case (state_reg)
      ST_IDLE, ST_LOSE: tmr_load = start;
      ST_WIN: begin
        tmr_load   = start | tmr_done;
        tmr_target = SHOW_T;
      end
      ST_SHOW_ON: begin
        tmr_load   = tmr_done;
        tmr_target = SHOW_T;
      end
      ST_PRE_GAP, ST_SHOW_OFF: begin
        tmr_load   = tmr_done;
        tmr_target = GAP_T;
      end
      ST_WAIT_IN: begin
        tmr_load   = press_edge | timeout_hit;
        tmr_target = TO_T;
      end
      ST_RELEASE: tmr_load = (player_input == 4'h0);
      default: ;
    endcase
  end

  tick_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .count  (tmr_count),
    .target (tmr_target),
    .done   (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      round_reg       <= '0;
      idx_reg         <= '0;
      check_round_reg <= '0;
      led_reg         <= 4'h0;
      prev_input_reg  <= 4'h0;
      busy_reg        <= 1'b0;
      over_reg        <= 1'b0;
      won_reg         <= 1'b0;
    end else begin
      prev_input_reg <= player_input;
      case (state_reg)
        ST_IDLE, ST_LOSE, ST_WIN: begin
          if (start) begin
            state_reg       <= ST_PRE_GAP;
            round_reg       <= '0;
            idx_reg         <= '0;
            check_round_reg <= '0;
            led_reg         <= 4'h0;
            busy_reg        <= 1'b1;
            over_reg        <= 1'b0;
            won_reg         <= 1'b0;
          end else if ((state_reg == ST_WIN) && tmr_done) begin
            led_reg <= ~led_reg;
          end
        end
        ST_PRE_GAP: begin
          if (tmr_done) begin
            state_reg <= ST_SHOW_ON;
            led_reg   <= code2led(segment[idx_reg]);
          end
        end
        ST_SHOW_ON: begin
          if (tmr_done) begin
            state_reg <= ST_SHOW_OFF;
            led_reg   <= 4'h0;
          end
        end
        ST_SHOW_OFF: begin
          if (tmr_done) begin
            if (idx_reg == round_reg) begin
              state_reg       <= ST_WAIT_IN;
              idx_reg         <= '0;
              check_round_reg <= '0;
              busy_reg        <= 1'b0;
            end else begin
              state_reg <= ST_SHOW_ON;
              idx_reg   <= idx_reg + 1'b1;
              led_reg   <= code2led(segment[idx_reg + 1'b1]);
            end
          end
        end
        ST_WAIT_IN: begin
          if (press_edge && sigs.result) begin
            state_reg <= ST_RELEASE;
            led_reg   <= player_input;
          end else if (press_edge || timeout_hit) begin
            state_reg <= ST_LOSE;
            led_reg   <= 4'hF;
            over_reg  <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (player_input != 4'h0) begin
            led_reg <= player_input;
          end else if (idx_reg != round_reg) begin
            state_reg       <= ST_WAIT_IN;
            idx_reg         <= idx_reg + 1'b1;
            check_round_reg <= idx_reg + 1'b1;
            led_reg         <= 4'h0;
          end else if (round_reg == LAST_ROUND) begin
            state_reg <= ST_WIN;
            led_reg   <= 4'b0101;
            won_reg   <= 1'b1;
          end else begin
            state_reg <= ST_PRE_GAP;
            round_reg <= round_reg + 1'b1;
            idx_reg   <= '0;
            led_reg   <= 4'h0;
            busy_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign sigs.check_round = check_round_reg;
  assign led_out          = led_reg;
  assign round            = round_reg;
  assign busy_show        = busy_reg;
  assign game_over        = over_reg;
  assign game_won         = won_reg;

endmodule
